// File: rtl/sha_logic_pipe.sv
// sha_logic_pipe
// Two-stage elastic bitwise logic unit for the SHA processor ALU. It sits
// between operand read and ALU writeback. It provides eight WIDTH-bit operations:
// AND, OR, XOR, NOT, SHA Ch, SHA Maj, rotate-right and logical shift-right.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset, clears both stage valid bits
//   in_valid   upstream offers an operation
//   in_ready   unit accepts the operation this cycle
//   op         operation select (000 AND, 001 OR, 010 XOR, 011 NOT,
//              100 CH, 101 MAJ, 110 ROTR, 111 SHR)
//   a, b, c    operands (c used by CH/MAJ only)
//   shamt      rotate/shift amount (ROTR/SHR only)
//   out_valid  result available
//   out_ready  downstream accepts the result
//   result     operation result, registered
//   zero       result == 0, registered
//   parity     XOR-reduction of result, registered
module sha_logic_pipe #(
    parameter int  WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    // WIDTH expressed in the shift-amount domain. One extra bit is kept so the
    // comparison against shamt is exact even when WIDTH is a power of two.
    localparam logic [SHW:0]   WIDTH_EXT = (SHW + 1)'(WIDTH);
    localparam logic [SHW-1:0] WIDTH_LO  = WIDTH_EXT[SHW-1:0];

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_c;
    logic [SHW-1:0]   s1_shamt;
    logic             s2_valid;
    logic             s2_ready;
    logic             in_fire;
    logic             s1_move;
    logic [SHW-1:0]   rot_amt;
    logic [WIDTH-1:0] alu_res;

    // Handshake plumbing. S2 can take new data when it is empty or being
    // drained this cycle. S1 can take new data when it is empty or moving into
    // S2. in_ready is held low while reset is asserted, so nothing is sampled
    // during the reset cycle.
    always_comb begin
        s2_ready  = !s2_valid || out_ready;
        in_ready  = !rst && (!s1_valid || s2_ready);
        in_fire   = in_valid && in_ready;
        s1_move   = s1_valid && s2_ready;
        out_valid = s2_valid;
    end

    // The operation is evaluated from the S1 registers and captured into S2.
    // For ROTR the amount wraps modulo WIDTH. shamt is always below 2*WIDTH, so
    // one conditional subtraction is enough. Rotation takes the low half of
    // {a,a} shifted right. SHR relies on the shift operator zero-filling, so
    // amounts >= WIDTH naturally give 0.
    always_comb begin
        rot_amt = s1_shamt;
        if ({1'b0, s1_shamt} >= WIDTH_EXT) begin
            rot_amt = s1_shamt - WIDTH_LO;
        end
        alu_res = '0;
        case (s1_op)
            3'b000:  alu_res = s1_a & s1_b;
            3'b001:  alu_res = s1_a | s1_b;
            3'b010:  alu_res = s1_a ^ s1_b;
            3'b011:  alu_res = ~s1_a;
            3'b100:  alu_res = (s1_a & s1_b) ^ (~s1_a & s1_c);
            3'b101:  alu_res = (s1_a & s1_b) ^ (s1_a & s1_c) ^ (s1_b & s1_c);
            3'b110:  alu_res = WIDTH'({s1_a, s1_a} >> rot_amt);
            3'b111:  alu_res = s1_a >> s1_shamt;
            default: alu_res = '0;
        endcase
    end

    // S1 operand registers only load on an input transfer. s1_valid decides
    // whether their contents mean anything, so they need no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_op    <= op;
            s1_a     <= a;
            s1_b     <= b;
            s1_c     <= c;
            s1_shamt <= shamt;
        end
    end

    // Valid bits and the S2 result registers. Reset discards anything in
    // flight. S1 refills on an input transfer, or empties when its contents
    // move on. S2 follows S1 whenever it can advance. The result registers
    // update only on an actual S1->S2 move, so they stay stable under
    // backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            parity   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            if (s1_move) begin
                result <= alu_res;
                zero   <= (alu_res == '0);
                parity <= ^alu_res;
            end
        end
    end

endmodule

// File: tb/tb_sha_logic_pipe.sv
// tb_sha_logic_pipe
// Directed bench for sha_logic_pipe at WIDTH=8. The stimulus pushes
// hand-computed results into a scoreboard queue. A monitor pops one entry per
// output transfer and compares it.
module tb_sha_logic_pipe;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       parity;
        int         acc;
        bit         chk_lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [2:0] shamt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       parity;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   out_count  = 0;
    int   push_count = 0;

    sha_logic_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .parity    (parity)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure acceptance-to-output latency.
    always @(posedge clk) begin
        cyc++;
    end

    // Hard stop so a stuck pipeline can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Offer one operation and wait (bounded) for it to be accepted. When
    // expect_out is set, the hand-computed result is queued for the monitor.
    // The acceptance edge is recorded for the latency check.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] ia,
                                 input logic [7:0] ib, input logic [7:0] ic,
                                 input logic [2:0] sh, input logic [7:0] exp_res,
                                 input bit expect_out, input bit chk_lat);
        int   waited;
        exp_t e;
        waited   = 0;
        op       = o;
        a        = ia;
        b        = ib;
        c        = ic;
        shamt    = sh;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        if (expect_out) begin
            e.res     = exp_res;
            e.zero    = (exp_res == 8'h00);
            e.parity  = ^exp_res;
            e.acc     = cyc + 1;
            e.chk_lat = chk_lat;
            sb.push_back(e);
            push_count++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait until every queued result has left the unit.
    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest queued result.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            out_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 64'(result), 64'(0));
                checks++;
                errors++;
                $display("[TB] FAIL extra_output: actual=%0d outputs required=%0d",
                         out_count, push_count);
            end else begin
                e = sb.pop_front();
                checkOutput("result", 64'(result), 64'(e.res));
                checkOutput("zero", 64'(zero), 64'(e.zero));
                checkOutput("parity", 64'(parity), 64'(e.parity));
                if (e.chk_lat) begin
                    checkOutput("latency_edge", 64'(cyc), 64'(e.acc + 1));
                end
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op        = 3'b000;
        a         = 8'hFF;
        b         = 8'hFF;
        c         = 8'h00;
        shamt     = 3'd0;

        // Reset held with in_valid high: nothing accepted, outputs cleared.
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
            checkOutput("rst_result", 64'(result), 64'(0));
            checkOutput("rst_zero", 64'(zero), 64'(0));
            checkOutput("rst_parity", 64'(parity), 64'(0));
            checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("post_rst_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        // Basic operations back-to-back, a=A5 b=3C c=F0.
        applyStimulus(3'b000, 8'hA5, 8'h3C, 8'hF0, 3'd0, 8'h24, 1, 1);
        applyStimulus(3'b001, 8'hA5, 8'h3C, 8'hF0, 3'd0, 8'hBD, 1, 1);
        applyStimulus(3'b010, 8'hA5, 8'h3C, 8'hF0, 3'd0, 8'h99, 1, 1);
        applyStimulus(3'b011, 8'hA5, 8'h3C, 8'hF0, 3'd0, 8'h5A, 1, 1);
        applyStimulus(3'b100, 8'hA5, 8'h3C, 8'hF0, 3'd0, 8'h74, 1, 1);
        applyStimulus(3'b101, 8'hA5, 8'h3C, 8'hF0, 3'd0, 8'hB4, 1, 1);

        // Rotate, shift and flag boundaries.
        applyStimulus(3'b110, 8'h81, 8'h00, 8'h00, 3'd1, 8'hC0, 1, 1);
        applyStimulus(3'b110, 8'h81, 8'h00, 8'h00, 3'd0, 8'h81, 1, 1);
        applyStimulus(3'b110, 8'h81, 8'h00, 8'h00, 3'd4, 8'h18, 1, 1);
        applyStimulus(3'b111, 8'h81, 8'h00, 8'h00, 3'd7, 8'h01, 1, 1);
        applyStimulus(3'b111, 8'h80, 8'h00, 8'h00, 3'd7, 8'h01, 1, 1);
        applyStimulus(3'b111, 8'hF0, 8'h00, 8'h00, 3'd0, 8'hF0, 1, 1);
        applyStimulus(3'b000, 8'h0F, 8'hF0, 8'h00, 3'd0, 8'h00, 1, 1);
        waitDrain();

        // Backpressure: two ops fill the pipe, the third is refused.
        out_ready = 1'b0;
        applyStimulus(3'b000, 8'hA5, 8'h3C, 8'h00, 3'd0, 8'h24, 1, 0);
        applyStimulus(3'b001, 8'hA5, 8'h3C, 8'h00, 3'd0, 8'hBD, 1, 0);
        op       = 3'b010;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
            checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
            checkOutput("bp_result_hold", 64'(result), 64'(8'h24));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(3'b010, 8'hA5, 8'h3C, 8'h00, 3'd0, 8'h99, 1, 0);
        waitDrain();

        // Simultaneous drain and accept with both stages full.
        out_ready = 1'b0;
        applyStimulus(3'b000, 8'hA5, 8'h3C, 8'h00, 3'd0, 8'h24, 1, 0);
        applyStimulus(3'b001, 8'hA5, 8'h3C, 8'h00, 3'd0, 8'hBD, 1, 0);
        n         = out_count;
        op        = 3'b010;
        a         = 8'hA5;
        b         = 8'h3C;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("sim_in_ready", 64'(in_ready), 64'(1));
        sb.push_back('{res: 8'h99, zero: 1'b0, parity: 1'b0, acc: 0, chk_lat: 1'b0});
        push_count++;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("sim_one_out", 64'(out_count), 64'(n + 1));
        checkOutput("sim_still_full", 64'(in_ready), 64'(0));
        checkOutput("sim_next_result", 64'(result), 64'(8'hBD));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain();

        // Reset mid-flight: both in-flight ops are discarded.
        out_ready = 1'b0;
        applyStimulus(3'b000, 8'hFF, 8'hFF, 8'h00, 3'd0, 8'hFF, 0, 0);
        applyStimulus(3'b001, 8'h12, 8'h34, 8'h00, 3'd0, 8'h36, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
            checkOutput("midrst_in_ready", 64'(in_ready), 64'(1));
        end
        @(posedge clk);
        #1;
        applyStimulus(3'b011, 8'h00, 8'h00, 8'h00, 3'd0, 8'hFF, 1, 1);
        waitDrain();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", 64'(sb.size()), 64'(0));
        checkOutput("output_count", 64'(out_count), 64'(push_count));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
